// File: rtl/divider_booth_inverse_if.sv
// Start/ready handshake bundle shared by the Booth multiplier and its inverse divider.
// The master launches an operation; the slave (the divider) returns the result and flags.
interface divider_booth_inverse_if #(
    parameter int W = 8
);
    logic                  start;
    logic signed [2*W-1:0] A;
    logic signed [W-1:0]   B;
    logic signed [W-1:0]   Quotient;
    logic signed [W-1:0]   Remainder;
    logic                  Overflow;
    logic                  DivZero;
    logic                  ready;

    modport master (
        output start, A, B,
        input  Quotient, Remainder, Overflow, DivZero, ready
    );

    modport slave (
        input  start, A, B,
        output Quotient, Remainder, Overflow, DivZero, ready
    );
endinterface

// File: rtl/divider_booth_inverse.sv
// Sequential signed divider (2W / W): restoring division on magnitudes, one quotient bit
// per cycle, followed by a sign fix-up that also raises overflow or divide-by-zero.
module divider_booth_inverse #(
    parameter int W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    divider_booth_inverse_if.slave  bus
);
    localparam int CW = $clog2(2*W);
    localparam logic [CW-1:0]  LAST_ITER = CW'(2*W-1);
    localparam logic [2*W-1:0] Q_LIM_POS = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [2*W-1:0] Q_LIM_NEG = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t          r_state, w_next;
    logic            r_sign_q, r_sign_r, r_bzero;
    logic [2*W-1:0]  r_dvd;       // dividend bits shift out at the top, quotient bits in at the bottom
    logic [W-1:0]    r_bmag;
    logic [W:0]      r_prem;
    logic [CW-1:0]   r_cnt;
    logic signed [W-1:0] r_quotient, r_remainder;
    logic            r_overflow, r_divzero, r_ready;

    logic            w_accept, w_qbit, w_ovf;
    logic [2*W-1:0]  w_a_mag;
    logic [W-1:0]    w_b_mag, w_q_fix, w_r_fix;
    logic [W:0]      w_prem_sh, w_prem_next;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = (bus.B == '0) ? S_FIX : S_CALC;
                end
            end
            S_CALC:  if (r_cnt == LAST_ITER) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_a_mag     = bus.A[2*W-1] ? (~bus.A + 1'b1) : bus.A;
        w_b_mag     = bus.B[W-1]   ? (~bus.B + 1'b1) : bus.B;
        w_prem_sh   = {r_prem[W-1:0], r_dvd[2*W-1]};
        w_qbit      = (w_prem_sh >= {1'b0, r_bmag});
        w_prem_next = w_qbit ? (w_prem_sh - {1'b0, r_bmag}) : w_prem_sh;
        // A negative quotient may reach one step further than a positive one.
        w_ovf       = r_sign_q ? (r_dvd > Q_LIM_NEG) : (r_dvd > Q_LIM_POS);
        w_q_fix     = r_sign_q ? (~r_dvd[W-1:0] + 1'b1) : r_dvd[W-1:0];
        w_r_fix     = r_sign_r ? (~r_prem[W-1:0] + 1'b1) : r_prem[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_bzero     <= 1'b0;
            r_dvd       <= '0;
            r_bmag      <= '0;
            r_prem      <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_overflow  <= 1'b0;
            r_divzero   <= 1'b0;
            r_ready     <= 1'b1;
        end else if (w_accept) begin
            r_sign_q <= bus.A[2*W-1] ^ bus.B[W-1];
            r_sign_r <= bus.A[2*W-1];
            r_bzero  <= (bus.B == '0);
            r_dvd    <= w_a_mag;
            r_bmag   <= w_b_mag;
            r_prem   <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b0;
        end else if (r_state == S_CALC) begin
            r_prem <= w_prem_next;
            r_dvd  <= {r_dvd[2*W-2:0], w_qbit};
            r_cnt  <= r_cnt + 1'b1;
        end else if (r_state == S_FIX) begin
            r_ready <= 1'b1;
            if (r_bzero) begin
                r_quotient  <= '0;
                r_remainder <= '0;
                r_overflow  <= 1'b0;
                r_divzero   <= 1'b1;
            end else begin
                r_quotient  <= w_ovf ? '0 : w_q_fix;
                r_remainder <= w_ovf ? '0 : w_r_fix;
                r_overflow  <= w_ovf;
                r_divzero   <= 1'b0;
            end
        end
    end

    assign bus.Quotient  = r_quotient;
    assign bus.Remainder = r_remainder;
    assign bus.Overflow  = r_overflow;
    assign bus.DivZero   = r_divzero;
    assign bus.ready     = r_ready;
endmodule

// File: tb/tb_divider_booth_inverse.sv
// Randomised and directed bench for divider_booth_inverse, checked against an integer
// division model (truncating quotient, dividend-signed remainder, range-checked quotient).
module tb_divider_booth_inverse;
    localparam int W = 8;
    localparam int LAT = 2*W + 1;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ovf;
        logic         dz;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    divider_booth_inverse_if #(.W(W)) bus ();

    divider_booth_inverse #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic res_t model(int a, int b);
        res_t e;
        int   q, r;
        e = '0;
        if (b == 0) begin
            e.dz = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            if (q > 127 || q < -128) e.ovf = 1'b1;
            else begin
                e.q = q[W-1:0];
                e.r = r[W-1:0];
            end
        end
        return e;
    endfunction

    function automatic res_t observed();
        return {bus.Quotient, bus.Remainder, bus.Overflow, bus.DivZero};
    endfunction

    task automatic launch(input logic signed [2*W-1:0] a, input logic signed [W-1:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = 16'($urandom);
        bus.B     = 8'($urandom);
    endtask

    task automatic wait_ready(inout int cycles);
        while (bus.ready !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.A     = 16'd100;
        bus.B     = 8'd7;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.ready, observed()} !== {1'b1, res_t'('0)}) begin
            errors++;
            $display("FAIL reset: got ready=%b res=%h, want ready=1 res=0", bus.ready, observed());
        end
        bus.start = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic test_directed();
        int   at [8] = '{100, -100, 1000, 16384, -16384, 16384, -32768, 55};
        int   bt [8] = '{7, 7, -8, -128, -128, 3, -1, 0};
        int   cycles;
        res_t exp_r;
        for (int i = 0; i < 8; i++) begin
            launch(16'(at[i]), 8'(bt[i]));
            cycles = 0;
            wait_ready(cycles);
            exp_r = model(at[i], bt[i]);
            checks++;
            if (cycles !== ((bt[i] == 0) ? 1 : LAT)) begin
                errors++;
                $display("FAIL latency %0d/%0d: got %0d cycles, want %0d", at[i], bt[i], cycles,
                         (bt[i] == 0) ? 1 : LAT);
            end
            checks++;
            if (observed() !== exp_r) begin
                errors++;
                $display("FAIL directed %0d/%0d: got {q,r,ovf,dz}=%h, want %h", at[i], bt[i],
                         observed(), exp_r);
            end
        end
    endtask

    task automatic test_ignored_start();
        int cycles = 0;
        launch(16'sd100, 8'sd7);
        while (cycles < 4) begin
            @(negedge clk);
            cycles++;
        end
        bus.start = 1'b1;
        bus.A     = 16'sd9;
        bus.B     = 8'sd3;
        @(negedge clk);
        cycles++;
        bus.start = 1'b0;
        wait_ready(cycles);
        checks++;
        if (cycles !== LAT || observed() !== model(100, 7)) begin
            errors++;
            $display("FAIL ignored_start: got %0d cycles res=%h, want %0d cycles res=%h",
                     cycles, observed(), LAT, model(100, 7));
        end
    endtask

    task automatic test_back_to_back();
        int cycles = 0;
        launch(16'sd9, 8'sd3);
        wait_ready(cycles);
        checks++;
        if (cycles !== LAT || observed() !== model(9, 3)) begin
            errors++;
            $display("FAIL back_to_back: got %0d cycles res=%h, want %0d cycles res=%h",
                     cycles, observed(), LAT, model(9, 3));
        end
    endtask

    task automatic test_reset_mid();
        int cycles = 0;
        launch(-16'sd1000, 8'sd9);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({bus.ready, observed()} !== {1'b1, res_t'('0)}) begin
            errors++;
            $display("FAIL reset_mid: got ready=%b res=%h, want ready=1 res=0", bus.ready, observed());
        end
        launch(-16'sd1000, 8'sd9);
        wait_ready(cycles);
        checks++;
        if (cycles !== LAT || observed() !== model(-1000, 9)) begin
            errors++;
            $display("FAIL after_reset: got %0d cycles res=%h, want %0d cycles res=%h",
                     cycles, observed(), LAT, model(-1000, 9));
        end
    endtask

    task automatic test_random();
        int   a, b, babs, cycles;
        res_t exp_r;
        for (int i = 0; i < 200; i++) begin
            b = int'($signed(8'($urandom)));
            if (i % 17 == 0) b = 0;
            babs = (b < 0) ? -b : b;
            if (i % 2 == 1 && b != 0)
                a = int'($urandom_range(0, 254 * babs)) - 127 * babs;
            else
                a = int'($signed(16'($urandom)));
            launch(16'(a), 8'(b));
            cycles = 0;
            wait_ready(cycles);
            exp_r = model(a, b);
            checks++;
            if (cycles !== ((b == 0) ? 1 : LAT) || observed() !== exp_r) begin
                errors++;
                $display("FAIL random %0d/%0d: got %0d cycles res=%h, want %0d cycles res=%h",
                         a, b, cycles, observed(), (b == 0) ? 1 : LAT, exp_r);
            end
            if (!exp_r.ovf && !exp_r.dz) begin
                checks++;
                if (int'(bus.Quotient) * b + int'(bus.Remainder) !== a) begin
                    errors++;
                    $display("FAIL invariant %0d/%0d: q=%0d r=%0d", a, b, bus.Quotient, bus.Remainder);
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        test_reset();
        test_directed();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
